rx_controller: RTL and testbench
================================

RX_CONTROLLER -- requirements
Module: rx_controller

Interface
REQ-001 Parameter stateCount, default 3, SHALL set the width of the one-hot state register.
REQ-002 Parameters idle, starting, receiving, defaults 3'b001, 3'b010, 3'b100, SHALL set the one-hot state encodings.
REQ-003 Parameter wordSize, default 8, SHALL set the number of data bits per frame.
REQ-004 Parameter overSample, default 8, SHALL set sample_tick pulses per bit time; it is even and at least 4.
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset; port list: clk input 1 (rising-edge clock); rst_b input 1 (asynchronous active-low reset).
REQ-006 serial_in input 1: UART line, idle high.
REQ-007 sample_tick input 1: one-clk strobe at overSample x baud.
REQ-008 read_not_ready_in input 1: host read strobe, one clk.
REQ-009 rx_data output wordSize: last delivered byte.
REQ-010 read_not_ready_out output 1: high when rx_data holds unread data.
REQ-011 error1 output 1: overrun flag.
REQ-012 error2 output 1: framing flag (stop bit low).
REQ-013 parity_error output 1: parity flag (tied 0 without RX_PARITY_EN).

Function
REQ-014 serial_in SHALL pass a 2-flop synchronizer; all decisions use the synchronized value.
REQ-015 State and counters SHALL advance only in clk cycles with sample_tick=1.
REQ-016 idle: on a tick with the line low, go to starting with sample counter cleared to 0.
REQ-017 starting: on a tick with the line high, return to idle (glitch reject).
REQ-018 starting: on a tick with the line low, increment sample counter; on reaching overSample/2-1, go to receiving with sample and bit counters cleared to 0.
REQ-019 receiving: each tick increments the sample counter; at overSample-1 the line SHALL be sampled, the sample counter cleared, and the bit counter incremented.
REQ-020 Data bits SHALL arrive LSB first and shift right into the shift register.
REQ-021 Frame length SHALL be wordSize data bits, plus 1 parity bit if enabled, plus 1 stop bit.
REQ-022 On the stop-bit sample, state SHALL return to idle in the same clk edge.
REQ-023 Valid stop (1) with read_not_ready_out=0: rx_data loads the shift register; read_not_ready_out sets 1 on the following edge.
REQ-024 Valid stop with read_not_ready_out=1 and no read_not_ready_in: rx_data SHALL be unchanged and error1 SHALL set.
REQ-025 Stop bit 0: error2 SHALL set and rx_data SHALL be unchanged.
REQ-026 read_not_ready_in=1 SHALL clear read_not_ready_out, error1, error2 and parity_error on the next edge.
REQ-027 read_not_ready_in coincident with frame completion: completion SHALL win; new data loads, read_not_ready_out stays 1, error1 is not set.
REQ-028 A new start bit SHALL be accepted on the tick immediately after the stop sample.

Reset
REQ-029 rst_b=0 SHALL asynchronously force state=idle, all counters 0, shift register 0, rx_data 0, and read_not_ready_out, error1, error2, parity_error 0.
REQ-030 Reset mid-frame SHALL discard the partial frame; no flag is raised after release.

Configuration
REQ-031 With macro RX_PARITY_EN defined, one even-parity bit SHALL follow the data bits; a mismatch sets parity_error, and rx_data still loads per REQ-023/024.
REQ-032 Without RX_PARITY_EN, no parity bit is expected and parity_error SHALL be constant 0.

Verification
REQ-033 Frame 0xA5, stop=1, host idle -> rx_data=0xA5, read_not_ready_out=1, all errors 0.
REQ-034 Line low for 2 ticks, then high -> state returns to idle; no output change.
REQ-035 Frame 0x5A with stop=0 -> error2=1, rx_data retains its previous value, read_not_ready_out unchanged.
REQ-036 0xA5, then 0x3C with no read -> rx_data=0xA5, error1=1; then read_not_ready_in pulse -> read_not_ready_out=0, error1=0.
REQ-037 RX_PARITY_EN: 0x01 with parity bit 0 -> parity_error=1, rx_data=0x01; with parity bit 1 -> parity_error=0.
REQ-038 rst_b low after bit 4 of 0xFF, then release and send 0x81 -> rx_data=0x81, no errors.

Source files
------------

// File: rtl/rx_controller.sv
// rx_controller -- oversampling UART receiver with single-entry holding register.
//
// The serial line is double-flop synchronized. A low level seen on a
// sample_tick starts start-bit qualification; after overSample/2-1 further low
// ticks the receiver is aligned near bit centre and samples every overSample
// ticks. Data bits arrive LSB first. The completed byte is handed to rx_data
// when the holding register is free (or is being read in the same cycle).
//
// Optional feature: define RX_PARITY_EN to expect one even-parity bit between
// the last data bit and the stop bit.
//
// Ports:
//   clk                 rising-edge clock
//   rst_b               asynchronous active-low reset
//   serial_in           UART line, idle high (asynchronous)
//   sample_tick         one-clk strobe at overSample x baud
//   read_not_ready_in   host read strobe, one clk
//   rx_data             last delivered data word
//   read_not_ready_out  rx_data holds unread data
//   error1              overrun: frame arrived while rx_data was unread
//   error2              framing error: stop bit sampled low
//   parity_error        even-parity mismatch (constant 0 without RX_PARITY_EN)

module rx_controller #(
    parameter int unsigned           stateCount = 3,
    parameter logic [stateCount-1:0] idle       = 3'b001,
    parameter logic [stateCount-1:0] starting   = 3'b010,
    parameter logic [stateCount-1:0] receiving  = 3'b100,
    parameter int unsigned           wordSize   = 8,
    parameter int unsigned           overSample = 8
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic                serial_in,
    input  logic                sample_tick,
    input  logic                read_not_ready_in,
    output logic [wordSize-1:0] rx_data,
    output logic                read_not_ready_out,
    output logic                error1,
    output logic                error2,
    output logic                parity_error
);

`ifdef RX_PARITY_EN
    localparam int unsigned PAR_BITS = 1;
`else
    localparam int unsigned PAR_BITS = 0;
`endif
    // Samples taken after the start bit: data, optional parity, stop.
    localparam int unsigned FRAME_BITS = wordSize + PAR_BITS + 1;
    localparam int unsigned SCNT_W     = $clog2(overSample);
    localparam int unsigned BCNT_W     = $clog2(FRAME_BITS);

    localparam logic [SCNT_W-1:0] SAMPLE_LAST = SCNT_W'(overSample - 1);
    localparam logic [SCNT_W-1:0] START_LAST  = SCNT_W'(overSample / 2 - 1);
    localparam logic [BCNT_W-1:0] BIT_STOP    = BCNT_W'(FRAME_BITS - 1);
    localparam logic [BCNT_W-1:0] BIT_DATA    = BCNT_W'(wordSize);

    typedef enum logic [stateCount-1:0] {
        ST_IDLE      = idle,
        ST_STARTING  = starting,
        ST_RECEIVING = receiving
    } state_t;

    state_t              state_q, state_d;
    logic                sync1_q, sync2_q;
    logic [SCNT_W-1:0]   scnt_q, scnt_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic [wordSize-1:0] shift_q, shift_d;
    logic [wordSize-1:0] rx_data_q, rx_data_d;
    logic                rnr_q, rnr_d;
    logic                err1_q, err1_d;
    logic                err2_q, err2_d;
    logic                frame_done;
    logic                stop_ok;
    logic                line;
    logic [SCNT_W-1:0]   scnt_inc;
`ifdef RX_PARITY_EN
    logic                par_bit_q, par_bit_d;
    logic                perr_q, perr_d;
`endif

    assign line     = sync2_q;
    assign scnt_inc = scnt_q + SCNT_W'(1);

    // Line synchronizer; resets to the idle level so release from reset
    // never looks like a start bit.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= serial_in;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= ST_IDLE;
            scnt_q    <= '0;
            bcnt_q    <= '0;
            shift_q   <= '0;
            rx_data_q <= '0;
            rnr_q     <= 1'b0;
            err1_q    <= 1'b0;
            err2_q    <= 1'b0;
`ifdef RX_PARITY_EN
            par_bit_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            scnt_q    <= scnt_d;
            bcnt_q    <= bcnt_d;
            shift_q   <= shift_d;
            rx_data_q <= rx_data_d;
            rnr_q     <= rnr_d;
            err1_q    <= err1_d;
            err2_q    <= err2_d;
`ifdef RX_PARITY_EN
            par_bit_q <= par_bit_d;
            perr_q    <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        scnt_d     = scnt_q;
        bcnt_d     = bcnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        rnr_d      = rnr_q;
        err1_d     = err1_q;
        err2_d     = err2_q;
        frame_done = 1'b0;
        stop_ok    = 1'b0;
`ifdef RX_PARITY_EN
        par_bit_d  = par_bit_q;
        perr_d     = perr_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (sample_tick && !line) begin
                    state_d = ST_STARTING;
                    scnt_d  = '0;
                end
            end
            ST_STARTING: begin
                if (sample_tick) begin
                    if (line) begin
                        state_d = ST_IDLE;
                    end else begin
                        scnt_d = scnt_inc;
                        if (scnt_inc == START_LAST) begin
                            state_d = ST_RECEIVING;
                            scnt_d  = '0;
                            bcnt_d  = '0;
                        end
                    end
                end
            end
            ST_RECEIVING: begin
                if (sample_tick) begin
                    if (scnt_q == SAMPLE_LAST) begin
                        scnt_d = '0;
                        bcnt_d = bcnt_q + BCNT_W'(1);
                        if (bcnt_q == BIT_STOP) begin
                            state_d    = ST_IDLE;
                            bcnt_d     = '0;
                            frame_done = 1'b1;
                            stop_ok    = line;
                        end else if (bcnt_q < BIT_DATA) begin
                            shift_d = {line, shift_q[wordSize-1:1]};
                        end else begin
`ifdef RX_PARITY_EN
                            par_bit_d = line;
`endif
                        end
                    end else begin
                        scnt_d = scnt_inc;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (read_not_ready_in) begin
            rnr_d  = 1'b0;
            err1_d = 1'b0;
            err2_d = 1'b0;
`ifdef RX_PARITY_EN
            perr_d = 1'b0;
`endif
        end

        // Completion overrides a coincident read: the read frees the holding
        // register, so the new word loads and the unread flag stays set.
        if (frame_done) begin
            if (stop_ok) begin
                if (!rnr_q || read_not_ready_in) begin
                    rx_data_d = shift_q;
                    rnr_d     = 1'b1;
                end else begin
                    err1_d = 1'b1;
                end
`ifdef RX_PARITY_EN
                if ((^shift_q) ^ par_bit_q) begin
                    perr_d = 1'b1;
                end
`endif
            end else begin
                err2_d = 1'b1;
            end
        end
    end

    assign rx_data            = rx_data_q;
    assign read_not_ready_out = rnr_q;
    assign error1             = err1_q;
    assign error2             = err2_q;
`ifdef RX_PARITY_EN
    assign parity_error       = perr_q;
`else
    assign parity_error       = 1'b0;
`endif

endmodule

// File: tb/tb_rx_controller.sv
// Scoreboard bench for rx_controller: stimulus pushes the expected output
// tuple {rx_data, read_not_ready_out, error1, error2, parity_error} for every
// output change it provokes; the monitor pops and compares on each change.
module tb_rx_controller;

    localparam int unsigned W  = 8;
    localparam int unsigned OS = 8;

    typedef logic [W+3:0] obs_t;

    logic         clk         = 1'b0;
    logic         rst_b       = 1'b0;
    logic         serial_in   = 1'b1;
    logic         sample_tick = 1'b0;
    logic         rnr_in      = 1'b0;
    logic [W-1:0] rx_data;
    logic         rnr_out;
    logic         error1;
    logic         error2;
    logic         parity_error;

    obs_t exp_q[$];
    obs_t prev_obs   = '0;
    int   vectors    = 0;
    int   miscompares = 0;
    logic [1:0] tdiv = '0;

    rx_controller #(
        .stateCount (3),
        .idle       (3'b001),
        .starting   (3'b010),
        .receiving  (3'b100),
        .wordSize   (W),
        .overSample (OS)
    ) dut (
        .clk                (clk),
        .rst_b              (rst_b),
        .serial_in          (serial_in),
        .sample_tick        (sample_tick),
        .read_not_ready_in  (rnr_in),
        .rx_data            (rx_data),
        .read_not_ready_out (rnr_out),
        .error1             (error1),
        .error2             (error2),
        .parity_error       (parity_error)
    );

    always #5 clk = ~clk;

    // One tick every 4 clocks, high for a whole cycle.
    always @(posedge clk) begin
        tdiv        <= tdiv + 2'd1;
        sample_tick <= (tdiv == 2'd2);
    end

    function automatic obs_t mk(input logic [W-1:0] d, input logic [3:0] f);
        return {d, f};
    endfunction

    // Monitor: every output change must match the oldest expectation.
    always @(negedge clk) begin
        obs_t cur;
        obs_t e;
        cur = {rx_data, rnr_out, error1, error2, parity_error};
        if (rst_b && (cur !== prev_obs)) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_change: rx_data=%h flags(rnr,e1,e2,pe)=%b, required no change from rx_data=%h flags=%b",
                         cur[W+3:4], cur[3:0], prev_obs[W+3:4], prev_obs[3:0]);
            end else begin
                e = exp_q.pop_front();
                if (cur !== e) begin
                    miscompares++;
                    $display("FAIL frame_result: rx_data=%h flags(rnr,e1,e2,pe)=%b, required rx_data=%h flags=%b",
                             cur[W+3:4], cur[3:0], e[W+3:4], e[3:0]);
                end
            end
        end
        prev_obs = cur;
    end

    task automatic check_direct(input string name, input obs_t e);
        obs_t c;
        c = {rx_data, rnr_out, error1, error2, parity_error};
        vectors++;
        if (c !== e) begin
            miscompares++;
            $display("FAIL %s: rx_data=%h flags(rnr,e1,e2,pe)=%b, required rx_data=%h flags=%b",
                     name, c[W+3:4], c[3:0], e[W+3:4], e[3:0]);
        end
    endtask

    // Leaves the bench at the negedge just before a tick edge.
    task automatic tick_setup();
        do @(negedge clk); while (sample_tick !== 1'b1);
    endtask

    task automatic tick();
        tick_setup();
        @(posedge clk);
        #1;
    endtask

    task automatic hold_bit(input logic v);
        serial_in = v;
        for (int t = 0; t < OS; t++) tick();
    endtask

    // Receiver samples the stop bit on the OS/2-th tick of the stop period;
    // the line returns high right after, so a low stop is not a break.
    task automatic send_frame(input logic [W-1:0] d, input logic stop,
                              input logic par, input bit coinc_read);
        tick();
        hold_bit(1'b0);
        for (int i = 0; i < W; i++) hold_bit(d[i]);
`ifdef RX_PARITY_EN
        hold_bit(par);
`else
        if (par === 1'bz) serial_in = 1'b1;
`endif
        serial_in = stop;
        for (int t = 1; t <= OS; t++) begin
            if (coinc_read && t == OS / 2) begin
                tick_setup();
                rnr_in = 1'b1;
                @(posedge clk);
                #1;
                rnr_in = 1'b0;
            end else begin
                tick();
            end
            if (t == OS / 2) serial_in = 1'b1;
        end
    endtask

    task automatic read_pulse(input logic [W-1:0] d);
        exp_q.push_back(mk(d, 4'b0000));
        @(negedge clk);
        rnr_in = 1'b1;
        @(negedge clk);
        rnr_in = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [7:0] ff;
        ff = 8'hFF;

        rst_b = 1'b0;
        repeat (4) @(negedge clk);
        check_direct("reset_state", '0);
        rst_b = 1'b1;
        repeat (8) @(negedge clk);

        // Clean frame, host idle.
        exp_q.push_back(mk(8'hA5, 4'b1000));
        send_frame(8'hA5, 1'b1, ^8'hA5, 0);
        read_pulse(8'hA5);

        // Two low ticks then high: start rejected, nothing changes.
        tick();
        serial_in = 1'b0;
        tick();
        tick();
        serial_in = 1'b1;
        repeat (2 * OS) tick();

        // Framing error keeps old data and unread flag.
        exp_q.push_back(mk(8'hA5, 4'b0010));
        send_frame(8'h5A, 1'b0, ^8'h5A, 0);
        read_pulse(8'hA5);

        // Overrun.
        exp_q.push_back(mk(8'hA5, 4'b1000));
        send_frame(8'hA5, 1'b1, ^8'hA5, 0);
        exp_q.push_back(mk(8'hA5, 4'b1100));
        send_frame(8'h3C, 1'b1, ^8'h3C, 0);
        read_pulse(8'hA5);

        // Read coincident with completion: new word loads, no overrun.
        exp_q.push_back(mk(8'h11, 4'b1000));
        send_frame(8'h11, 1'b1, ^8'h11, 0);
        exp_q.push_back(mk(8'h22, 4'b1000));
        send_frame(8'h22, 1'b1, ^8'h22, 1);
        read_pulse(8'h22);

`ifdef RX_PARITY_EN
        exp_q.push_back(mk(8'h01, 4'b1001));
        send_frame(8'h01, 1'b1, 1'b0, 0);
        read_pulse(8'h01);
        exp_q.push_back(mk(8'h01, 4'b1000));
        send_frame(8'h01, 1'b1, 1'b1, 0);
        read_pulse(8'h01);
`endif

        // Reset after bit 4 of 0xFF discards the partial frame.
        tick();
        hold_bit(1'b0);
        for (int i = 0; i < 5; i++) hold_bit(ff[i]);
        @(negedge clk);
        rst_b = 1'b0;
        serial_in = 1'b1;
        repeat (3) @(negedge clk);
        check_direct("mid_frame_reset", '0);
        rst_b = 1'b1;
        repeat (12 * OS) tick();
        exp_q.push_back(mk(8'h81, 4'b1000));
        send_frame(8'h81, 1'b1, ^8'h81, 0);
        read_pulse(8'h81);

        for (int c = 0; c < 200 && exp_q.size() != 0; c++) @(negedge clk);
        while (exp_q.size() != 0) begin
            obs_t e;
            e = exp_q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missing_event: no output change seen, required rx_data=%h flags=%b",
                     e[W+3:4], e[3:0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
